// File: rtl/memu_pkg.sv
// Shared widths, memory-op encodings and the execute-to-memory bundle layout
// for the memory-access stage.
package memu_pkg;

    localparam int EXE2MEM_LEN = 213;
    localparam int MEM2WB_LEN  = 207;
    localparam int MEM_RF_LEN  = 40;

    localparam logic [3:0] MEM_OP_LD_B  = 4'd0;
    localparam logic [3:0] MEM_OP_LD_H  = 4'd1;
    localparam logic [3:0] MEM_OP_LD_W  = 4'd2;
    localparam logic [3:0] MEM_OP_ST_B  = 4'd4;
    localparam logic [3:0] MEM_OP_ST_H  = 4'd5;
    localparam logic [3:0] MEM_OP_ST_W  = 4'd6;
    localparam logic [3:0] MEM_OP_LD_BU = 4'd8;
    localparam logic [3:0] MEM_OP_LD_HU = 4'd9;

    // Execute-stage bundle, first field is the MSB of the flat vector.
    typedef struct packed {
        logic        mem_req;
        logic        res_from_mem;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] result;
        logic [3:0]  mem_op;
        logic [31:0] pc;
        logic        csr_read;
        logic        csr_we;
        logic [13:0] csr_num;
        logic [31:0] csr_wmask;
        logic [31:0] csr_wvalue;
        logic [31:0] vaddr;
        logic        ex_valid;
        logic [5:0]  ecode;
        logic [8:0]  esubcode;
        logic        is_ertn;
        logic [2:0]  tlb_op;
        logic [4:0]  invtlb_op;
    } exe2mem_t;

endpackage

// File: rtl/memu_load_align.sv
// Picks the addressed byte/halfword out of a load response and extends it
// according to the load flavour. Purely combinational.
module memu_load_align
    import memu_pkg::*;
(
    input  logic [3:0]  mem_op,
    input  logic [1:0]  offset,
    input  logic [31:0] rdata,
    output logic [31:0] value
);

    logic [7:0]  lane [4];
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign lane[gi] = rdata[8*gi +: 8];
    end

    assign sel_byte = lane[offset];
    assign sel_half = offset[1] ? rdata[31:16] : rdata[15:0];

    // Extend the selected lane; word loads and anything else pass through.
    always_comb begin
        value = rdata;
        case (mem_op)
            MEM_OP_LD_B:  value = {{24{sel_byte[7]}}, sel_byte};
            MEM_OP_LD_H:  value = {{16{sel_half[15]}}, sel_half};
            MEM_OP_LD_BU: value = {24'd0, sel_byte};
            MEM_OP_LD_HU: value = {16'd0, sel_half};
            default:      value = rdata;
        endcase
    end

endmodule

// File: rtl/memu.sv
// Memory-access pipeline stage: holds the execute bundle until its data
// response arrives, aligns load data, and forwards to writeback/decode.
// Responses belonging to flushed instructions are counted and dropped.
module memu
    import memu_pkg::*;
(
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   flush,
    output logic                   mem_allowin,
    input  logic                   exe_to_mem_valid,
    input  logic [EXE2MEM_LEN-1:0] exe_to_mem_zip,
    input  logic                   data_sram_data_ok,
    input  logic [31:0]            data_sram_rdata,
    input  logic                   wb_allowin,
    output logic                   mem_to_wb_valid,
    output logic [MEM2WB_LEN-1:0]  mem_to_wb_zip,
    output logic [MEM_RF_LEN-1:0]  mem_rf_zip,
    output logic                   mem_ex
);

    exe2mem_t    exe_zip;
    exe2mem_t    zip_reg;
    logic        mem_valid_reg;
    logic        resp_got_reg;
    logic [31:0] rdata_buf_reg;
    logic [1:0]  cancel_cnt_reg;
    logic [1:0]  cancel_cnt_next;
    logic [1:0]  cancel_inc;
    logic [1:0]  cancel_dec;

    logic        cancel_idle;
    logic        data_ok_live;
    logic        mem_ready_go;
    logic        capture;
    logic        live_pending;
    logic        load_wait;
    logic [31:0] load_raw;
    logic [31:0] load_value;
    logic [31:0] final_result;

    assign exe_zip      = exe_to_mem_zip;
    assign cancel_idle  = (cancel_cnt_reg == 2'd0);
    // A response only belongs to the live instruction once all cancelled ones drained.
    assign data_ok_live = data_sram_data_ok & cancel_idle;
    assign mem_ready_go = ~zip_reg.mem_req | resp_got_reg | data_ok_live;
    assign mem_allowin  = ~mem_valid_reg | (mem_ready_go & wb_allowin);
    assign capture      = exe_to_mem_valid & mem_allowin;
    assign mem_to_wb_valid = mem_valid_reg & mem_ready_go;

    // Live request whose response is still in flight and will not arrive this cycle.
    assign live_pending = mem_valid_reg & zip_reg.mem_req & ~resp_got_reg & ~data_ok_live;

    // Capture the execute bundle on handshake.
    always_ff @(posedge clk) begin
        if (capture) begin
            zip_reg <= exe_zip;
        end
    end

    // Stage valid; a flush kills whatever would be in the stage next cycle.
    always_ff @(posedge clk) begin
        if (!resetn || flush) begin
            mem_valid_reg <= 1'b0;
        end else if (mem_allowin) begin
            mem_valid_reg <= exe_to_mem_valid;
        end
    end

    // Remember the response when WB cannot take the result immediately.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            resp_got_reg <= 1'b0;
        end else if (capture) begin
            resp_got_reg <= 1'b0;
        end else if (mem_valid_reg && zip_reg.mem_req && !resp_got_reg && data_ok_live) begin
            resp_got_reg <= 1'b1;
        end
    end

    // Response data buffer, loaded together with resp_got.
    always_ff @(posedge clk) begin
        if (!capture && mem_valid_reg && zip_reg.mem_req && !resp_got_reg && data_ok_live) begin
            rdata_buf_reg <= data_sram_rdata;
        end
    end

    // Cancel count: add orphaned requests on flush, retire one per dropped response.
    always_comb begin
        cancel_inc = 2'd0;
        if (flush) begin
            cancel_inc = {1'b0, live_pending} + {1'b0, capture & exe_zip.mem_req};
        end
        cancel_dec      = {1'b0, data_sram_data_ok & ~cancel_idle};
        cancel_cnt_next = cancel_cnt_reg + cancel_inc - cancel_dec;
    end

    // Cancel counter register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cancel_cnt_reg <= 2'd0;
        end else begin
            cancel_cnt_reg <= cancel_cnt_next;
        end
    end

    assign load_raw = resp_got_reg ? rdata_buf_reg : data_sram_rdata;

    memu_load_align u_load_align (
        .mem_op (zip_reg.mem_op),
        .offset (zip_reg.result[1:0]),
        .rdata  (load_raw),
        .value  (load_value)
    );

    assign final_result = zip_reg.res_from_mem ? load_value : zip_reg.result;
    // Decode must stall on a load whose data is not yet available.
    assign load_wait    = zip_reg.res_from_mem & ~mem_ready_go;

    assign mem_to_wb_zip = {zip_reg.rf_we, zip_reg.rf_waddr, final_result, zip_reg.pc,
                            zip_reg.csr_read, zip_reg.csr_we, zip_reg.csr_num,
                            zip_reg.csr_wmask, zip_reg.csr_wvalue, zip_reg.vaddr,
                            zip_reg.ex_valid, zip_reg.ecode, zip_reg.esubcode,
                            zip_reg.is_ertn, zip_reg.tlb_op, zip_reg.invtlb_op};

    assign mem_rf_zip = {mem_valid_reg & zip_reg.csr_read, mem_valid_reg & load_wait,
                         mem_valid_reg & zip_reg.rf_we, zip_reg.rf_waddr, final_result};

    assign mem_ex = mem_valid_reg & (zip_reg.ex_valid | zip_reg.is_ertn);

endmodule

// File: tb/tb_memu.sv
// Self-checking bench for memu: directed scenarios plus a scoreboard of
// expected writeback results compared whenever WB accepts a bundle.
module tb_memu;
    import memu_pkg::*;

    logic                   clk = 1'b0;
    logic                   resetn;
    logic                   flush;
    logic                   mem_allowin;
    logic                   exe_to_mem_valid;
    logic [EXE2MEM_LEN-1:0] exe_to_mem_zip;
    logic                   data_sram_data_ok;
    logic [31:0]            data_sram_rdata;
    logic                   wb_allowin;
    logic                   mem_to_wb_valid;
    logic [MEM2WB_LEN-1:0]  mem_to_wb_zip;
    logic [MEM_RF_LEN-1:0]  mem_rf_zip;
    logic                   mem_ex;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] res;
    } sb_t;

    sb_t sb_q[$];
    int  checks = 0;
    int  errors = 0;

    always #5 clk = ~clk;

    memu dut (
        .clk               (clk),
        .resetn            (resetn),
        .flush             (flush),
        .mem_allowin       (mem_allowin),
        .exe_to_mem_valid  (exe_to_mem_valid),
        .exe_to_mem_zip    (exe_to_mem_zip),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .wb_allowin        (wb_allowin),
        .mem_to_wb_valid   (mem_to_wb_valid),
        .mem_to_wb_zip     (mem_to_wb_zip),
        .mem_rf_zip        (mem_rf_zip),
        .mem_ex            (mem_ex)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [3:0] op, input logic [31:0] addr,
                                               input logic [31:0] rdata);
        logic [31:0] sh;
        sh = rdata >> {addr[1:0], 3'b000};
        case (op)
            4'd0:    return {{24{sh[7]}}, sh[7:0]};
            4'd1:    return {{16{sh[15]}}, sh[15:0]};
            4'd8:    return {24'd0, sh[7:0]};
            4'd9:    return {16'd0, sh[15:0]};
            default: return rdata;
        endcase
    endfunction

    function automatic exe2mem_t make_zip(input logic mem_req, input logic res_from_mem,
                                          input logic [31:0] result, input logic [3:0] op,
                                          input logic [31:0] pc, input logic ex_valid);
        exe2mem_t z;
        z              = '0;
        z.mem_req      = mem_req;
        z.res_from_mem = res_from_mem;
        z.rf_we        = 1'b1;
        z.rf_waddr     = pc[6:2];
        z.result       = result;
        z.mem_op       = op;
        z.pc           = pc;
        z.vaddr        = result;
        z.ex_valid     = ex_valid;
        return z;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a bundle and hold it until the stage accepts it (bounded).
    task automatic send(input exe2mem_t z);
        int n;
        n = 0;
        exe_to_mem_valid = 1'b1;
        exe_to_mem_zip   = z;
        #1;
        while (!mem_allowin && n < 20) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (!mem_allowin) check_val("send_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        exe_to_mem_valid = 1'b0;
    endtask

    // Scoreboard: every bundle WB accepts must match the oldest expectation.
    always @(negedge clk) begin
        if (resetn && mem_to_wb_valid && wb_allowin && !flush) begin
            if (sb_q.size() == 0) begin
                check_val("wb_unexpected", 64'(sb_q.size()), 64'd1);
            end else begin
                sb_t exp_e;
                exp_e = sb_q.pop_front();
                check_val("wb_result", {mem_to_wb_zip[168:137], mem_to_wb_zip[200:169]}, exp_e);
                $display("WB pc=%h result=%h", mem_to_wb_zip[168:137], mem_to_wb_zip[200:169]);
            end
        end
    end

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] rdata;
        logic        is_load;
    } vec_t;

    initial begin
        vec_t     vecs[6];
        exe2mem_t z;
        logic [31:0] pc;

        resetn = 1'b0; flush = 1'b0; exe_to_mem_valid = 1'b0; exe_to_mem_zip = '0;
        data_sram_data_ok = 1'b0; data_sram_rdata = '0; wb_allowin = 1'b1;
        repeat (3) tick();
        check_val("rst_wb_valid", 64'(mem_to_wb_valid), 64'd0);
        check_val("rst_mem_ex", 64'(mem_ex), 64'd0);
        check_val("rst_rf_valid_bits", 64'(mem_rf_zip[39:37]), 64'd0);
        check_val("rst_cancel_cnt", 64'(dut.cancel_cnt_reg), 64'd0);
        resetn = 1'b1;
        tick();

        // ld.b at offset 3, response on the second cycle in stage
        pc = 32'h1c00_0100;
        sb_q.push_back({pc, 32'hFFFF_FF80});
        send(make_zip(1'b1, 1'b1, 32'h0000_1003, MEM_OP_LD_B, pc, 1'b0));
        #1;
        check_val("ldb_wait_valid", 64'(mem_to_wb_valid), 64'd0);
        check_val("ldb_load_wait", 64'(mem_rf_zip[38]), 64'd1);
        tick();
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h8012_3456;
        #1;
        check_val("ldb_valid_on_ok", 64'(mem_to_wb_valid), 64'd1);
        check_val("ldb_fwd_result", 64'(mem_rf_zip[31:0]), 64'hFFFF_FF80);
        tick();
        data_sram_data_ok = 1'b0;
        #1;
        check_val("ldb_exit", 64'(mem_to_wb_valid), 64'd0);

        // ld.bu same address and data
        pc = 32'h1c00_0104;
        sb_q.push_back({pc, 32'h0000_0080});
        send(make_zip(1'b1, 1'b1, 32'h0000_1003, MEM_OP_LD_BU, pc, 1'b0));
        tick();
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h8012_3456;
        #1;
        check_val("ldbu_fwd_result", 64'(mem_rf_zip[31:0]), 64'h0000_0080);
        tick();
        data_sram_data_ok = 1'b0;

        // ld.h offset 2 with WB stalled around the response
        pc = 32'h1c00_0108;
        sb_q.push_back({pc, 32'hFFFF_8001});
        send(make_zip(1'b1, 1'b1, 32'h0000_2002, MEM_OP_LD_H, pc, 1'b0));
        wb_allowin = 1'b0;
        tick();
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h8001_0000;
        tick();
        data_sram_data_ok = 1'b0; data_sram_rdata = 32'hDEAD_BEEF;
        #1;
        check_val("ldh_held_valid", 64'(mem_to_wb_valid), 64'd1);
        check_val("ldh_held_result", 64'(mem_rf_zip[31:0]), 64'hFFFF_8001);
        check_val("ldh_held_load_wait", 64'(mem_rf_zip[38]), 64'd0);
        tick();
        data_sram_rdata = 32'h1234_5678;
        tick();
        wb_allowin = 1'b1;
        #1;
        check_val("ldh_release_result", 64'(mem_rf_zip[31:0]), 64'hFFFF_8001);
        tick();
        #1;
        check_val("ldh_exit", 64'(mem_to_wb_valid), 64'd0);

        // Mixed lanes/flavours, response on the first cycle in stage
        vecs[0] = '{MEM_OP_LD_H,  32'h0000_3000, 32'h1234_F00D, 1'b1};
        vecs[1] = '{MEM_OP_LD_HU, 32'h0000_3002, 32'hBEEF_0000, 1'b1};
        vecs[2] = '{MEM_OP_LD_B,  32'h0000_3001, 32'h0000_7F00, 1'b1};
        vecs[3] = '{MEM_OP_LD_BU, 32'h0000_3000, 32'h0000_00F1, 1'b1};
        vecs[4] = '{MEM_OP_LD_W,  32'h0000_3004, 32'hA5A5_5A5A, 1'b1};
        vecs[5] = '{MEM_OP_ST_W,  32'h0000_3008, 32'h0BAD_0BAD, 1'b0};
        for (int i = 0; i < 6; i++) begin
            pc = 32'h1c00_0200 + 32'(i * 4);
            sb_q.push_back({pc, vecs[i].is_load ?
                            model_load(vecs[i].op, vecs[i].addr, vecs[i].rdata) : vecs[i].addr});
            send(make_zip(1'b1, vecs[i].is_load, vecs[i].addr, vecs[i].op, pc, 1'b0));
            data_sram_data_ok = 1'b1; data_sram_rdata = vecs[i].rdata;
            #1;
            check_val("vec_valid", 64'(mem_to_wb_valid), 64'd1);
            tick();
            data_sram_data_ok = 1'b0;
        end

        // Flush with a live load outstanding, then flush while a new load enters
        pc = 32'h1c00_0300;
        send(make_zip(1'b1, 1'b1, 32'h0000_4000, MEM_OP_LD_W, pc, 1'b0));
        flush = 1'b1;
        exe_to_mem_valid = 1'b1;
        exe_to_mem_zip = make_zip(1'b1, 1'b1, 32'h0000_4004, MEM_OP_LD_W, pc + 32'd4, 1'b0);
        #1;
        check_val("flush_live_allowin", 64'(mem_allowin), 64'd0);
        tick();
        check_val("flush1_cancel_cnt", 64'(dut.cancel_cnt_reg), 64'd1);
        tick();
        flush = 1'b0; exe_to_mem_valid = 1'b0;
        #1;
        check_val("flush2_cancel_cnt", 64'(dut.cancel_cnt_reg), 64'd2);
        check_val("flush2_wb_valid", 64'(mem_to_wb_valid), 64'd0);
        pc = 32'h1c00_0308;
        sb_q.push_back({pc, 32'hCAFE_F00D});
        send(make_zip(1'b1, 1'b1, 32'h0000_4008, MEM_OP_LD_W, pc, 1'b0));
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h1111_1111;
        #1;
        check_val("drop1_valid", 64'(mem_to_wb_valid), 64'd0);
        tick();
        data_sram_rdata = 32'h2222_2222;
        #1;
        check_val("drop2_cancel_cnt", 64'(dut.cancel_cnt_reg), 64'd1);
        check_val("drop2_valid", 64'(mem_to_wb_valid), 64'd0);
        tick();
        data_sram_rdata = 32'hCAFE_F00D;
        #1;
        check_val("third_cancel_cnt", 64'(dut.cancel_cnt_reg), 64'd0);
        check_val("third_valid", 64'(mem_to_wb_valid), 64'd1);
        check_val("third_result", 64'(mem_rf_zip[31:0]), 64'hCAFE_F00D);
        tick();
        data_sram_data_ok = 1'b0;

        // Flush coinciding with the live load's own response
        send(make_zip(1'b1, 1'b1, 32'h0000_5000, MEM_OP_LD_W, 32'h1c00_0400, 1'b0));
        flush = 1'b1; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h0000_0055;
        tick();
        flush = 1'b0; data_sram_data_ok = 1'b0;
        #1;
        check_val("flush_ok_cancel_cnt", 64'(dut.cancel_cnt_reg), 64'd0);
        check_val("flush_ok_wb_valid", 64'(mem_to_wb_valid), 64'd0);

        // Non-memory instruction carrying an exception
        pc = 32'h1c00_0500;
        sb_q.push_back({pc, 32'h1234_5678});
        send(make_zip(1'b0, 1'b0, 32'h1234_5678, 4'd0, pc, 1'b1));
        #1;
        check_val("add_mem_ex", 64'(mem_ex), 64'd1);
        check_val("add_wb_valid", 64'(mem_to_wb_valid), 64'd1);
        check_val("add_load_wait", 64'(mem_rf_zip[38]), 64'd0);
        check_val("add_rf_we", 64'(mem_rf_zip[37]), 64'd1);
        tick();
        check_val("add_mem_ex_gone", 64'(mem_ex), 64'd0);

        // Reset in the middle of a load with a cancelled response pending
        send(make_zip(1'b1, 1'b1, 32'h0000_6000, MEM_OP_LD_W, 32'h1c00_0600, 1'b0));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        send(make_zip(1'b1, 1'b1, 32'h0000_6004, MEM_OP_LD_W, 32'h1c00_0604, 1'b1));
        #1;
        check_val("pre_rst_mem_ex", 64'(mem_ex), 64'd1);
        check_val("pre_rst_cancel_cnt", 64'(dut.cancel_cnt_reg), 64'd1);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        #1;
        check_val("mid_rst_wb_valid", 64'(mem_to_wb_valid), 64'd0);
        check_val("mid_rst_mem_ex", 64'(mem_ex), 64'd0);
        check_val("mid_rst_rf_valid_bits", 64'(mem_rf_zip[39:37]), 64'd0);
        check_val("mid_rst_cancel_cnt", 64'(dut.cancel_cnt_reg), 64'd0);

        // Stage works normally after reset
        pc = 32'h1c00_0700;
        sb_q.push_back({pc, 32'h0000_0042});
        send(make_zip(1'b0, 1'b0, 32'h0000_0042, 4'd0, pc, 1'b0));
        repeat (3) tick();
        check_val("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
